// File: rtl/mem_access_ctrl_pkg.sv
// mem_access_ctrl_pkg: op codes, FSM states, memory size and request legality shared by controller and bench
package mem_access_ctrl_pkg;
  localparam int unsigned DEF_DATA_MEM_SIZE = 128;
  typedef enum logic [3:0] {
    OP_LB = 4'd0, OP_LH = 4'd1, OP_LW = 4'd2, OP_LBU = 4'd4, OP_LHU = 4'd5,
    OP_SB = 4'd8, OP_SH = 4'd9, OP_SW = 4'd10
  } op_e;
  typedef enum logic [2:0] {S_IDLE, S_RD, S_CAP, S_WR, S_DONE} state_e;
  function automatic logic req_legal(logic [3:0] op, logic [31:0] addr, logic [31:0] size);
    return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW} && addr < size
      && !((op inside {OP_LW, OP_SW}) && addr[1:0] != 2'b00)
      && !((op inside {OP_LH, OP_LHU, OP_SH}) && addr[0]);
  endfunction
endpackage

// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if: CPU request/response and word-port memory signals
interface mem_access_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] MemAddr;
  logic [31:0] MemWriteData;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] MemReadData;
  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, MemReadData,
    output req_ready, resp_valid, resp_rdata, resp_err, MemAddr, MemWriteData, MemWrite, MemRead
  );
  modport master (
    output req_valid, req_op, req_addr, req_wdata, MemReadData,
    input  req_ready, resp_valid, resp_rdata, resp_err, MemAddr, MemWriteData, MemWrite, MemRead
  );
endinterface

// File: rtl/mem_access_ctrl_lane_unit.sv
// lane_unit: big-endian lane extraction/extension for loads and lane merge for SB/SH
module lane_unit
  import mem_access_ctrl_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [1:0]  off,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);
  logic [4:0]  sh;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  always_comb begin
    sh = {2'd3 - off, 3'b000};
    byte_v = 8'(word >> sh);
    half_v = off[1] ? word[15:0] : word[31:16];
    load_data = op == OP_LB  ? {{24{byte_v[7]}}, byte_v} :
                op == OP_LBU ? {24'b0, byte_v} :
                op == OP_LH  ? {{16{half_v[15]}}, half_v} :
                op == OP_LHU ? {16'b0, half_v} : word;
    store_word = op == OP_SB ? (word & ~(32'hFF << sh)) | ({24'b0, wdata[7:0]} << sh) :
                 op == OP_SH ? (off[1] ? {word[31:16], wdata[15:0]} : {wdata[15:0], word[15:0]}) : wdata;
  end
endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: byte/half/word CPU accesses onto a word-wide data memory port
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int unsigned DATA_MEM_SIZE = DEF_DATA_MEM_SIZE
) (
  input logic clk,
  input logic rst,
  mem_access_ctrl_if.slave bus
);
  state_e      state_q, state_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        legal;
  logic [31:0] load_word, store_word;
  lane_unit u_lane (
    .op(op_q), .off(addr_q[1:0]), .word(bus.MemReadData), .wdata(wdata_q),
    .load_data(load_word), .store_word(store_word)
  );
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d = err_q;
    legal = req_legal(bus.req_op, bus.req_addr, DATA_MEM_SIZE);
    case (state_q)
      S_IDLE: if (bus.req_valid) begin
        op_d = bus.req_op;
        addr_d = bus.req_addr;
        wdata_d = bus.req_wdata;
        err_d = !legal;
        state_d = !legal ? S_DONE : bus.req_op == OP_SW ? S_WR : S_RD;
      end
      S_RD: state_d = S_CAP;
      // wdata_q is reused to hold the merged word for the following WR
      S_CAP: begin
        rdata_d = op_q[3] ? rdata_q : load_word;
        wdata_d = store_word;
        state_d = op_q[3] ? S_WR : S_DONE;
      end
      S_WR: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q <= err_d;
    end
  end
  assign bus.req_ready = state_q == S_IDLE;
  assign bus.resp_valid = state_q == S_DONE;
  assign bus.resp_err = state_q == S_DONE && err_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.MemAddr = {addr_q[31:2], 2'b00};
  assign bus.MemWriteData = wdata_q;
  assign bus.MemRead = state_q == S_RD;
  assign bus.MemWrite = state_q == S_WR;
endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter: DATA_MEM_SIZE, default 128, data memory size in bytes; valid addresses are 0..DATA_MEM_SIZE-1.
REQ-002 Ports: clk  in  1  sole clock, all state updates on posedge.
REQ-003 Ports: rst  in  1  reset, synchronous and active-high.
REQ-004 Ports: req_valid  in  1  CPU access request valid.
REQ-005 Ports: req_ready  out  1  controller idle, request accepted when req_valid & req_ready at posedge.
REQ-006 Ports: req_op  in  4  LB=0, LH=1, LW=2, LBU=4, LHU=5, SB=8, SH=9, SW=10; all other codes illegal.
REQ-007 Ports: req_addr  in  32  byte address; req_wdata  in  32  store data, right-justified for SB/SH.
REQ-008 Ports: resp_valid  out  1  one-cycle completion pulse; resp_rdata  out  32  load result; resp_err  out  1  access rejected.
REQ-009 Ports: MemAddr  out  32 / MemWriteData  out  32 / MemWrite  out  1 / MemRead  out  1  word-port request to data memory.
REQ-010 Ports: MemReadData  in  32  registered memory read data.

Function
REQ-011 Memory port contract: a memory read issued in cycle N (MemRead=1) returns MemReadData valid from cycle N+1; a write (MemWrite=1) commits at the posedge ending its cycle; MemRead and MemWrite SHALL never be 1 in the same cycle.
REQ-012 MemAddr SHALL always be the captured address with bits [1:0] forced to 0; MemRead/MemWrite SHALL be 0 outside RD/WR states.
REQ-013 Byte order is big-endian: byte offset k occupies word bits [31-8k:24-8k]; halfword offset 0 = [31:16], offset 2 = [15:0].
REQ-014 FSM states: IDLE, RD, CAP, WR, DONE; req_ready=1 only in IDLE.
REQ-015 IDLE accept: capture op, addr, wdata; illegal op, addr >= DATA_MEM_SIZE, LW/SW with addr[1:0]!=0, or LH/LHU/SH with addr[0]!=0 -> DONE with err, no memory access.
REQ-016 Legal SW: IDLE -> WR (MemWriteData=wdata) -> DONE; resp_valid 2 cycles after accept.
REQ-017 Legal load: IDLE -> RD -> CAP -> DONE; CAP registers the extracted lane (zero-extend LBU/LHU, sign-extend LB/LH, full word LW) into resp_rdata; resp_valid 3 cycles after accept.
REQ-018 Legal SB/SH: IDLE -> RD -> CAP (merge wdata[7:0]/[15:0] into addressed lane of MemReadData, other lanes unchanged) -> WR (merged word) -> DONE; resp_valid 4 cycles after accept.
REQ-019 DONE: resp_valid=1 for exactly one cycle, then IDLE; resp_err=1 only with error responses, else 0.
REQ-020 resp_rdata SHALL hold its value until the next load completes; stores and errors leave it unchanged.
REQ-021 req_valid while not in IDLE SHALL be ignored; back-to-back requests are accepted no earlier than the cycle after DONE.
REQ-022 Upper address edge: addr = DATA_MEM_SIZE-4 word and DATA_MEM_SIZE-1 byte are legal.

Reset
REQ-023 rst=1 at posedge SHALL force IDLE, resp_valid=0, resp_err=0, resp_rdata=0, MemRead=0, MemWrite=0 in the following cycle.
REQ-024 Reset mid-operation SHALL abort without any later MemWrite; an SB/SH aborted before WR leaves memory unchanged; no resp_valid for the aborted request.

Structure
REQ-025 Op codes, FSM state encoding and DATA_MEM_SIZE default SHALL reside in a shared package used by CPU and bench.
REQ-026 One sub-module, lane_unit, SHALL be combinational: load extraction/extension and store merge from (op, addr[1:0], word, wdata).

Verification
REQ-027 SW 0x11223344 @0x10, then LW @0x10 -> MemWrite one cycle with MemAddr=0x10; load resp_rdata=0x11223344, resp_err=0, latencies 2 and 3.
REQ-028 After REQ-027, SB 0xAA @0x12 then LW @0x10 -> MemRead then MemWrite of 0x1122AA44; load returns 0x1122AA44.
REQ-029 Word 0x80FF7F01 @0x20: LB @0x20 -> 0xFFFFFF80; LBU @0x21 -> 0x000000FF; LH @0x22 -> 0x00007F01; LHU @0x20 -> 0x000080FF.
REQ-030 LW @0x13, SH @0x21, LB @0x80, op=3 -> each resp_err=1 one cycle after accept, no MemRead/MemWrite, resp_rdata unchanged.
REQ-031 Assert rst during CAP of SH @0x30 -> no MemWrite, no resp_valid, next LW @0x30 returns original word.
REQ-032 Hold req_valid=1 continuously with changing ops -> req_ready only in IDLE, each request completes once, no lost or duplicated accesses.
